// File: rtl/apb_csr_pkg.sv
// Purpose: shared types, register map indices and helpers for the APB CSR bank.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package apb_csr_pkg;

   // Bus phase tracked by the slave: the phase the bus was in on the previous cycle.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int unsigned IDX_W     = 10;   // word index = PADDR[11:2]
   localparam int unsigned ID_IDX    = 0;
   localparam int unsigned CTRL_BASE = 1;

   function automatic int unsigned stat_base(input int unsigned num_ctrl);
      return CTRL_BASE + num_ctrl;
   endfunction

   function automatic int unsigned irq_status_idx(input int unsigned num_ctrl,
                                                  input int unsigned num_stat);
      return CTRL_BASE + num_ctrl + num_stat;
   endfunction

   function automatic int unsigned irq_en_idx(input int unsigned num_ctrl,
                                              input int unsigned num_stat);
      return CTRL_BASE + num_ctrl + num_stat + 1;
   endfunction

   // Expand 4 byte strobes into a 32-bit bit mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/apb_csr_bank_if.sv
// Purpose: APB3 bus bundle between a requester (master) and the CSR bank (slave).
// Latency: n/a (wires only).
// Backpressure: slave stalls the access phase by holding PREADY low.
// Signals: PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB requester->slave; PRDATA/PREADY/PSLVERR back.
interface apb_csr_bank_if;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_wait_ctrl.sv
// Purpose: APB phase tracker plus access-phase wait counter; emits PREADY and write-commit strobe.
// Latency: PREADY rises after WAIT_STATES stalled access cycles (0 = first access cycle).
// Backpressure: holds PREADY low while counting; PSEL drop mid-wait abandons the transfer.
// Ports: CLK, RESET, psel/penable/pwrite in; pready, commit, setup_stb out.
module apb_wait_ctrl
   import apb_csr_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic CLK,
   input  logic RESET,
   input  logic psel,
   input  logic penable,
   input  logic pwrite,
   output logic pready,
   output logic commit,
   output logic setup_stb
);

   apb_state_e state_q, state_d;
   logic [3:0] cnt_q;
   logic       acc_ok;

   // An access phase is only honoured if it directly follows a SETUP (or an
   // ongoing ACCESS); a bus left in PENABLE after reset must start over.
   assign setup_stb = psel & ~penable;
   assign acc_ok    = psel & penable & ((state_q == ST_SETUP) || (state_q == ST_ACCESS));
   assign pready    = acc_ok & (cnt_q == 4'(WAIT_STATES));
   assign commit    = pready & pwrite;

   always_comb begin
      state_d = ST_IDLE;
      if (setup_stb) begin
         state_d = ST_SETUP;
      end else if (acc_ok && !pready) begin
         state_d = ST_ACCESS;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (acc_ok && !pready) ? cnt_q + 4'd1 : 4'd0;
      end
   end

endmodule

// File: rtl/apb_csr_bank.sv
// Purpose: APB3 CSR slave: ID word, RW control regs, RO status, W1C IRQ status + enable.
// Latency: read data/error captured in SETUP; completes after WAIT_STATES access stalls; irq_o +1 cycle.
// Backpressure: PREADY low during wait states; PSLVERR only alongside PREADY.
// Ports: CLK, RESET, apb (slave modport), ctrl_o, stat_i, irq_src_i, irq_o.
module apb_csr_bank
   import apb_csr_pkg::*;
#(
   parameter int unsigned NUM_CTRL    = 4,
   parameter int unsigned NUM_STAT    = 4,
   parameter int unsigned IRQ_W       = 8,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'h5A5A5A5A
) (
   input  logic                  CLK,
   input  logic                  RESET,
   apb_csr_bank_if.slave         apb,
   output logic [NUM_CTRL*32-1:0] ctrl_o,
   input  logic [NUM_STAT*32-1:0] stat_i,
   input  logic [IRQ_W-1:0]      irq_src_i,
   output logic                  irq_o
);

   localparam int unsigned STAT_IDX   = stat_base(NUM_CTRL);
   localparam int unsigned IRQ_ST_IDX = irq_status_idx(NUM_CTRL, NUM_STAT);
   localparam int unsigned IRQ_EN_IDX = irq_en_idx(NUM_CTRL, NUM_STAT);

   logic [IDX_W-1:0] idx, idx_q;
   logic [31:0]      rd_mux, rdata_q, st_ext, en_ext, wmask, wbits;
   logic             rd_err, err_q;
   logic             pready, commit, setup_stb, wr_en;
   logic [31:0]      ctrl_q [NUM_CTRL];
   logic [IRQ_W-1:0] irq_st_q, irq_en_q, irq_clr;
   logic             irq_q;
   logic             unused_addr;

   assign idx         = apb.PADDR[11:2];
   assign unused_addr = ^{apb.PADDR[31:12], apb.PADDR[1:0]};

   apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait (
      .CLK       (CLK),
      .RESET     (RESET),
      .psel      (apb.PSEL),
      .penable   (apb.PENABLE),
      .pwrite    (apb.PWRITE),
      .pready    (pready),
      .commit    (commit),
      .setup_stb (setup_stb)
   );

   // Read mux over the live register state; anything not matched is an error.
   always_comb begin
      st_ext               = '0;
      en_ext               = '0;
      st_ext[IRQ_W-1:0]    = irq_st_q;
      en_ext[IRQ_W-1:0]    = irq_en_q;
      rd_mux               = '0;
      rd_err               = 1'b1;
      if (idx == IDX_W'(ID_IDX)) begin
         rd_mux = ID_VALUE;
         rd_err = 1'b0;
      end
      for (int i = 0; i < NUM_CTRL; i++) begin
         if (idx == IDX_W'(CTRL_BASE + i)) begin
            rd_mux = ctrl_q[i];
            rd_err = 1'b0;
         end
      end
      for (int i = 0; i < NUM_STAT; i++) begin
         if (idx == IDX_W'(STAT_IDX + i)) begin
            rd_mux = stat_i[32*i +: 32];
            rd_err = 1'b0;
         end
      end
      if (idx == IDX_W'(IRQ_ST_IDX)) begin
         rd_mux = st_ext;
         rd_err = 1'b0;
      end
      if (idx == IDX_W'(IRQ_EN_IDX)) begin
         rd_mux = en_ext;
         rd_err = 1'b0;
      end
   end

   // Decode and read data are frozen at SETUP; the access phase only waits.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         idx_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else if (setup_stb) begin
         idx_q   <= idx;
         err_q   <= rd_err;
         rdata_q <= rd_mux;
      end
   end

   assign wr_en       = commit & ~err_q;
   assign wmask       = strb_mask(apb.PSTRB);
   assign wbits       = apb.PWDATA & wmask;
   assign irq_clr     = (wr_en && idx_q == IDX_W'(IRQ_ST_IDX)) ? wbits[IRQ_W-1:0] : '0;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
         irq_st_q <= '0;
         irq_en_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CTRL; i++) begin
            if (wr_en && idx_q == IDX_W'(CTRL_BASE + i)) begin
               ctrl_q[i] <= (ctrl_q[i] & ~wmask) | wbits;
            end
         end
         if (wr_en && idx_q == IDX_W'(IRQ_EN_IDX)) begin
            irq_en_q <= (irq_en_q & ~wmask[IRQ_W-1:0]) | wbits[IRQ_W-1:0];
         end
         // A source that is high this cycle beats a simultaneous W1C.
         irq_st_q <= (irq_st_q & ~irq_clr) | irq_src_i;
         irq_q    <= |(irq_st_q & irq_en_q);
      end
   end

   for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
      assign ctrl_o[32*g +: 32] = ctrl_q[g];
   end

   assign irq_o       = irq_q;
   assign apb.PRDATA  = rdata_q;
   assign apb.PREADY  = pready;
   assign apb.PSLVERR = pready & err_q;

endmodule

// File: tb/tb_apb_csr_bank.sv
// Purpose: directed self-checking bench for apb_csr_bank with a register-level model.
// Latency: n/a.
// Backpressure: bench master honours WAIT_STATES and checks PREADY each access cycle.
module tb_apb_csr_bank;

   localparam int NC = 4;
   localparam int NS = 4;
   localparam int IW = 8;
   localparam int WS = 3;
   localparam logic [31:0] ID = 32'h5A5A5A5A;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   apb_csr_bank_if bus ();
   logic [NC*32-1:0] ctrl_o;
   logic [NS*32-1:0] stat_i;
   logic [IW-1:0]    irq_src;
   logic             irq_o;

   apb_csr_bank #(
      .NUM_CTRL(NC), .NUM_STAT(NS), .IRQ_W(IW), .WAIT_STATES(WS), .ID_VALUE(ID)
   ) dut (
      .CLK(CLK), .RESET(RESET), .apb(bus), .ctrl_o(ctrl_o),
      .stat_i(stat_i), .irq_src_i(irq_src), .irq_o(irq_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- register-level model ----------------
   logic [31:0] m_ctrl [NC];
   logic [IW-1:0] m_st, m_en;
   logic m_irq;
   bit   m_commit;
   int   m_idx;
   logic [31:0] m_wd;
   logic [3:0]  m_strb;

   function automatic bit mapped(input int idx);
      return idx >= 0 && idx <= NC + NS + 2;
   endfunction

   function automatic logic [31:0] mread(input int idx);
      if (idx == 0) return ID;
      if (idx >= 1 && idx <= NC) return m_ctrl[idx-1];
      if (idx > NC && idx <= NC + NS) return stat_i[32*(idx-NC-1) +: 32];
      if (idx == NC + NS + 1) return 32'(m_st);
      if (idx == NC + NS + 2) return 32'(m_en);
      return 32'h0;
   endfunction

   always @(posedge CLK) begin : model
      logic [31:0] mask, wb;
      logic [IW-1:0] clr;
      if (RESET) begin
         for (int i = 0; i < NC; i++) m_ctrl[i] = '0;
         m_st = '0; m_en = '0; m_irq = 1'b0; m_commit = 0;
      end else begin
         m_irq = |(m_st & m_en);
         mask  = {{8{m_strb[3]}}, {8{m_strb[2]}}, {8{m_strb[1]}}, {8{m_strb[0]}}};
         wb    = m_wd & mask;
         clr   = '0;
         if (m_commit) begin
            if (m_idx >= 1 && m_idx <= NC) m_ctrl[m_idx-1] = (m_ctrl[m_idx-1] & ~mask) | wb;
            if (m_idx == NC + NS + 1) clr = wb[IW-1:0];
            if (m_idx == NC + NS + 2) m_en = (m_en & ~mask[IW-1:0]) | wb[IW-1:0];
         end
         m_st = (m_st & ~clr) | irq_src;
         m_commit = 0;
      end
   end

   // Every-cycle comparison of the persistent outputs.
   always @(negedge CLK) begin
      if (started && !RESET) begin
         for (int i = 0; i < NC; i++) check("ctrl_o", ctrl_o[32*i +: 32], m_ctrl[i]);
         check("irq_o", 32'(irq_o), 32'(m_irq));
         check("pslverr_gate", 32'(bus.PSLVERR & ~bus.PREADY), 32'h0);
      end
   end

   // ---------------- bus master ----------------
   logic [31:0] last_rd;
   logic        last_err;

   task automatic xfer(input bit wr, input int idx, input logic [31:0] wd,
                       input logic [3:0] sb, input int abort_at = -1, input int reset_at = -1);
      logic [31:0] exp_rd;
      bit exp_err;
      exp_rd = mread(idx);
      exp_err = !mapped(idx);
      bus.PADDR = {20'h0, 10'(idx), 2'b00};
      bus.PWRITE = wr; bus.PWDATA = wd; bus.PSTRB = sb;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      @(posedge CLK); #1;
      bus.PENABLE = 1'b1;
      for (int k = 0; k <= WS; k++) begin
         if (k == abort_at || k == reset_at) begin
            bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
            if (k == reset_at) RESET = 1'b1;
            @(posedge CLK); #1;
            @(posedge CLK); #1;
            RESET = 1'b0;
            return;
         end
         @(negedge CLK);
         check("pready", 32'(bus.PREADY), 32'(k == WS));
         if (k == WS) begin
            check("pslverr", 32'(bus.PSLVERR), 32'(exp_err));
            if (!wr) check("prdata", bus.PRDATA, exp_rd);
            last_rd = bus.PRDATA;
            last_err = bus.PSLVERR;
            if (wr && !exp_err) begin
               m_commit = 1; m_idx = idx; m_wd = wd; m_strb = sb;
            end
         end
         @(posedge CLK); #1;
      end
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   initial begin
      irq_src = '0;
      for (int i = 0; i < NS; i++) stat_i[32*i +: 32] = 32'h5747_0000 + 32'(i);
      bus.PADDR = '0; bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
      bus.PWDATA = '0; bus.PSTRB = '0;
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      started = 1;

      // Reset state
      @(negedge CLK);
      check("rst_prdata", bus.PRDATA, 32'h0);
      check("rst_pready", 32'(bus.PREADY), 32'h0);
      check("rst_irq", 32'(irq_o), 32'h0);
      check("rst_ctrl3", ctrl_o[127:96], 32'h0);
      @(posedge CLK); #1;

      // ID read
      xfer(0, 0, 32'h0, 4'h0);
      check("id_lit", last_rd, 32'h5A5A5A5A);
      check("id_err", 32'(last_err), 32'h0);

      // Byte-strobed write and readback
      xfer(1, 1, 32'hDEADBEEF, 4'b0101);
      check("ctrl0_lit", ctrl_o[31:0], 32'h00AD00EF);
      xfer(0, 1, 32'h0, 4'h0);
      check("ctrl0_rd_lit", last_rd, 32'h00AD00EF);

      // Back-to-back write then read
      xfer(1, 4, 32'h12345678, 4'hF);
      xfer(0, 4, 32'h0, 4'h0);
      check("ctrl3_rd_lit", last_rd, 32'h12345678);

      // Status reads; writes to RO words ignored without error
      for (int i = NC + 1; i <= NC + NS; i++) xfer(0, i, 32'h0, 4'h0);
      check("stat_last_lit", last_rd, 32'h57470003);
      xfer(1, 6, 32'hFFFFFFFF, 4'hF);
      check("ro_wr_err", 32'(last_err), 32'h0);
      xfer(1, 0, 32'h0, 4'hF);
      xfer(0, 0, 32'h0, 4'h0);
      check("id_after_wr", last_rd, ID);

      // PSEL dropped mid-wait: no commit
      xfer(1, 2, 32'hCAFEF00D, 4'hF, 2);
      check("abort_ctrl1", ctrl_o[63:32], 32'h0);
      xfer(0, 2, 32'h0, 4'h0);

      // Unmapped words
      xfer(0, 10'h3FF, 32'h0, 4'h0);
      check("unm_rd_err", 32'(last_err), 32'h1);
      check("unm_rd_dat", last_rd, 32'h0);
      xfer(1, 10'h3FF, 32'hFFFFFFFF, 4'hF);
      check("unm_wr_err", 32'(last_err), 32'h1);
      xfer(0, NC + NS + 3, 32'h0, 4'h0);
      check("first_unm_err", 32'(last_err), 32'h1);

      // Interrupts
      xfer(1, NC + NS + 2, 32'hFFFFFF04, 4'hF);
      xfer(0, NC + NS + 2, 32'h0, 4'h0);
      check("irq_en_lit", last_rd, 32'h00000004);
      irq_src[2] = 1'b1;
      @(posedge CLK); #1;
      irq_src[2] = 1'b0;
      @(posedge CLK); #1;
      check("irq_o_lit", 32'(irq_o), 32'h1);
      irq_src[2] = 1'b1;
      xfer(1, NC + NS + 1, 32'h4, 4'hF);
      xfer(0, NC + NS + 1, 32'h0, 4'h0);
      check("w1c_setwins", last_rd, 32'h4);
      irq_src[2] = 1'b0;
      xfer(1, NC + NS + 1, 32'h4, 4'hF);
      xfer(0, NC + NS + 1, 32'h0, 4'h0);
      check("w1c_clear", last_rd, 32'h0);
      repeat (2) @(posedge CLK);
      #1 check("irq_o_off", 32'(irq_o), 32'h0);

      // Reset during access of a write
      xfer(1, 1, 32'h55667788, 4'hF, -1, 1);
      check("rst_mid_ctrl0", ctrl_o[31:0], 32'h0);
      check("rst_mid_ctrl3", ctrl_o[127:96], 32'h0);
      xfer(1, 1, 32'h11223344, 4'hF);
      xfer(0, 1, 32'h0, 4'h0);
      check("post_rst_rd", last_rd, 32'h11223344);

      repeat (2) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
